// File: rtl/soc_mem_pkg.sv
// Shared memory-subsystem definitions: bus widths, requester encoding and MMIO map.
package soc_mem_pkg;
  localparam int AW_DEF = 19;
  localparam int DW_DEF = 19;
  localparam logic [18:0] MMIO_BASE = 19'h7F000;

  typedef enum logic {OWN_CPU = 1'b0, OWN_ACC = 1'b1} owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } rd_slot_t;
endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks issued reads for RD_LAT cycles so each return is tagged with its owner.
// Latency RD_LAT; no backpressure, one push per cycle, flushed by reset.
module mem_rd_tracker
  import soc_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_vld,
  input  owner_e push_owner,
  output logic   tail_vld,
  output owner_e tail_owner
);
  rd_slot_t pipe [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: push_vld, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail_vld   = pipe[RD_LAT-1].vld;
  assign tail_owner = pipe[RD_LAT-1].owner;
endmodule

// File: rtl/mem_arbiter.sv
// CPU/accelerator round-robin arbiter for the shared data memory, with bounded accelerator bursts.
// Grant is same-cycle; read data returns RD_LAT cycles later; a losing requester holds until granted.
module mem_arbiter
  import soc_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

  owner_e        winner;
  owner_e        last_gnt;
  owner_e        tail_owner;
  logic          tail_vld;
  logic          locked;
  logic          lock_nxt;
  logic          lock_gnt;
  logic          gnt_vld;
  logic          win_we;
  logic [BW-1:0] burst_cnt;

  assign gnt_vld = (m0_req | m1_req) & ~rst;

  always_comb begin
    winner = OWN_CPU;
    if (m0_req && m1_req) begin
      if (locked && burst_cnt < BURST_LIM) winner = OWN_ACC;
      else if (last_gnt == OWN_CPU)        winner = OWN_ACC;
    end else if (m1_req) begin
      winner = OWN_ACC;
    end
  end

  always_comb begin
    win_we    = m0_we;
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (winner == OWN_ACC) begin
      win_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
    m0_gnt    = gnt_vld && (winner == OWN_CPU);
    m1_gnt    = gnt_vld && (winner == OWN_ACC);
    mem_write = gnt_vld & win_we;
    mem_read  = gnt_vld & ~win_we;
  end

  // A CPU grant always ends the burst; otherwise the lock follows the accelerator's request.
  assign lock_gnt = m1_gnt & m1_lock;

  always_comb begin
    lock_nxt = locked;
    if (m0_gnt)                 lock_nxt = 1'b0;
    else if (lock_gnt)          lock_nxt = 1'b1;
    else if (!m1_lock || !m1_req) lock_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= OWN_ACC;
      locked    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (gnt_vld) last_gnt <= winner;
      locked <= lock_nxt;
      if (!lock_nxt)
        burst_cnt <= '0;
      else if (lock_gnt && m0_req && burst_cnt != BURST_LIM)
        burst_cnt <= burst_cnt + BW'(1);
    end
  end

  mem_rd_tracker #(.RD_LAT(RD_LAT)) u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .push_vld   (mem_read),
    .push_owner (winner),
    .tail_vld   (tail_vld),
    .tail_owner (tail_owner)
  );

  assign m0_rvalid = tail_vld && (tail_owner == OWN_CPU);
  assign m1_rvalid = tail_vld && (tail_owner == OWN_ACC);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus burst-lock and reset-in-flight sequences.
// Instance u_a uses RD_LAT=1, u_b uses RD_LAT=2; both see identical requests.
module tb_mem_arbiter;
  import soc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [18:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_g0, a_g1, a_v0, a_v1, a_mw, a_mr;
  logic [18:0] a_d0, a_d1, a_addr, a_wdata, a_rdata;
  logic        b_g0, b_g1, b_v0, b_v1, b_mw, b_mr;
  logic [18:0] b_d0, b_d1, b_addr, b_wdata, b_rdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(1), .MAX_BURST(8)) u_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_g0), .m0_rvalid(a_v0), .m0_rdata(a_d0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(a_g1), .m1_rvalid(a_v1), .m1_rdata(a_d1),
    .mem_write(a_mw), .mem_read(a_mr), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata)
  );

  mem_arbiter #(.RD_LAT(2), .MAX_BURST(8)) u_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_g0), .m0_rvalid(b_v0), .m0_rdata(b_d0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(b_g1), .m1_rvalid(b_v1), .m1_rdata(b_d1),
    .mem_write(b_mw), .mem_read(b_mr), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata)
  );

  // Memory model: writes land at the edge, reads return after 1 (u_a) or 2 (u_b) edges.
  logic [18:0] mem_q [logic [18:0]];
  logic [18:0] b_stage;

  function automatic logic [18:0] rd_mem(input logic [18:0] a);
    return mem_q.exists(a) ? mem_q[a] : 19'd0;
  endfunction

  always @(posedge clk) begin
    if (a_mw) mem_q[a_addr] = a_wdata;
    a_rdata <= a_mr ? rd_mem(a_addr) : 19'd0;
    b_stage <= b_mr ? rd_mem(b_addr) : 19'd0;
    b_rdata <= b_stage;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        m0_req, m0_we;
    logic [18:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [18:0] m1_addr, m1_wdata;
    logic        e_g0, e_g1, e_wr, e_rd;
    logic [18:0] e_addr, e_wdata;
    logic        e_v0;
    logic [18:0] e_d0;
    logic        e_v1;
    logic [18:0] e_d1;
  } vec_t;

  function automatic vec_t mk(input int q0, w0, a0, d0, q1, w1, lk, a1, d1,
                              g0, g1, wr, rd, ea, ed, v0, r0, v1, r1);
    vec_t r;
    r.m0_req = q0[0];  r.m0_we = w0[0];  r.m0_addr = a0[18:0]; r.m0_wdata = d0[18:0];
    r.m1_req = q1[0];  r.m1_we = w1[0];  r.m1_lock = lk[0];
    r.m1_addr = a1[18:0]; r.m1_wdata = d1[18:0];
    r.e_g0 = g0[0]; r.e_g1 = g1[0]; r.e_wr = wr[0]; r.e_rd = rd[0];
    r.e_addr = ea[18:0]; r.e_wdata = ed[18:0];
    r.e_v0 = v0[0]; r.e_d0 = r0[18:0]; r.e_v1 = v1[0]; r.e_d1 = r1[18:0];
    return r;
  endfunction

  task automatic apply(input vec_t v);
    m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_lock = v.m1_lock;
    m1_addr = v.m1_addr; m1_wdata = v.m1_wdata;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, " a_g0"}, a_g0, 0); chk1({tag, " a_g1"}, a_g1, 0);
    chk1({tag, " a_mw"}, a_mw, 0); chk1({tag, " a_mr"}, a_mr, 0);
    chk1({tag, " a_v0"}, a_v0, 0); chk1({tag, " a_v1"}, a_v1, 0);
    chkw({tag, " a_d0"}, a_d0, 0); chkw({tag, " a_d1"}, a_d1, 0);
    chkw({tag, " a_addr"}, a_addr, 0); chkw({tag, " a_wdata"}, a_wdata, 0);
    chk1({tag, " b_g0"}, b_g0, 0); chk1({tag, " b_g1"}, b_g1, 0);
    chk1({tag, " b_mw"}, b_mw, 0); chk1({tag, " b_mr"}, b_mr, 0);
    chk1({tag, " b_v0"}, b_v0, 0); chk1({tag, " b_v1"}, b_v1, 0);
    chkw({tag, " b_d0"}, b_d0, 0); chkw({tag, " b_d1"}, b_d1, 0);
    chkw({tag, " b_addr"}, b_addr, 0); chkw({tag, " b_wdata"}, b_wdata, 0);
  endtask

  localparam int NV = 14;
  vec_t vt [NV];
  int   n_g1;

  initial begin
    //            q0 w0 a0      d0   q1 w1 lk a1      d1  g0 g1 wr rd ea      ed   v0 r0   v1 r1
    vt[0]  = mk(1, 1, 100,    138, 0, 0, 0, 0,      0,  1, 0, 1, 0, 100,    138, 0, 0,   0, 0);
    vt[1]  = mk(1, 0, 100,    0,   0, 0, 0, 0,      0,  1, 0, 0, 1, 100,    0,   0, 0,   0, 0);
    vt[2]  = mk(0, 0, 0,      0,   1, 1, 0, 200,    55, 0, 1, 1, 0, 200,    55,  1, 138, 0, 0);
    vt[3]  = mk(1, 0, 100,    0,   1, 0, 0, 200,    0,  1, 0, 0, 1, 100,    0,   0, 0,   0, 0);
    vt[4]  = mk(1, 0, 100,    0,   1, 0, 0, 200,    0,  0, 1, 0, 1, 200,    0,   1, 138, 0, 0);
    vt[5]  = mk(1, 0, 100,    0,   1, 0, 0, 200,    0,  1, 0, 0, 1, 100,    0,   0, 0,   1, 55);
    vt[6]  = mk(1, 0, 100,    0,   1, 0, 0, 200,    0,  0, 1, 0, 1, 200,    0,   1, 138, 0, 0);
    vt[7]  = mk(0, 0, 0,      0,   0, 0, 0, 0,      0,  0, 0, 0, 0, 0,      0,   0, 0,   1, 55);
    vt[8]  = mk(1, 1, 'h7F000, 138, 0, 0, 0, 0,     0,  1, 0, 1, 0, 'h7F000, 138, 0, 0,  0, 0);
    vt[9]  = mk(0, 0, 0,      0,   1, 0, 0, 'h7F000, 0, 0, 1, 0, 1, 'h7F000, 0,  0, 0,   0, 0);
    vt[10] = mk(0, 0, 0,      0,   0, 0, 0, 0,      0,  0, 0, 0, 0, 0,      0,   0, 0,   1, 138);
    vt[11] = mk(1, 0, 300,    0,   1, 0, 0, 100,    0,  1, 0, 0, 1, 300,    0,   0, 0,   0, 0);
    vt[12] = mk(0, 0, 0,      0,   1, 0, 0, 100,    0,  0, 1, 0, 1, 100,    0,   1, 0,   0, 0);
    vt[13] = mk(0, 0, 0,      0,   0, 0, 0, 0,      0,  0, 0, 0, 0, 0,      0,   0, 0,   1, 138);

    // Reset with both requesting: every grant and strobe must stay low.
    idle();
    rst = 1;
    m0_req = 1; m1_req = 1; m1_we = 1;
    @(negedge clk);
    chk_quiet("reset");
    next_cycle();
    rst = 0;
    idle();

    for (int i = 0; i < NV; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk1($sformatf("v%0d m0_gnt", i), a_g0, vt[i].e_g0);
      chk1($sformatf("v%0d m1_gnt", i), a_g1, vt[i].e_g1);
      chk1($sformatf("v%0d mem_write", i), a_mw, vt[i].e_wr);
      chk1($sformatf("v%0d mem_read", i), a_mr, vt[i].e_rd);
      chkw($sformatf("v%0d mem_addr", i), a_addr, vt[i].e_addr);
      chkw($sformatf("v%0d mem_wdata", i), a_wdata, vt[i].e_wdata);
      chk1($sformatf("v%0d m0_rvalid", i), a_v0, vt[i].e_v0);
      chkw($sformatf("v%0d m0_rdata", i), a_d0, vt[i].e_d0);
      chk1($sformatf("v%0d m1_rvalid", i), a_v1, vt[i].e_v1);
      chkw($sformatf("v%0d m1_rdata", i), a_d1, vt[i].e_d1);
      next_cycle();
    end

    // Burst: accelerator takes the lock alone, then holds it for 8 grants while the CPU waits.
    idle();
    m1_req = 1; m1_lock = 1; m1_addr = 5;
    @(negedge clk);
    chk1("burst start m1_gnt", a_g1, 1);
    next_cycle();
    m0_req = 1; m0_addr = 9;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1($sformatf("burst %0d m1_gnt", k), a_g1, 1);
      chk1($sformatf("burst %0d m0_gnt", k), a_g0, 0);
      next_cycle();
    end
    @(negedge clk);
    chk1("burst release m0_gnt", a_g0, 1);
    chk1("burst release m1_gnt", a_g1, 0);
    next_cycle();
    chkw("burst_cnt after release", 19'(u_a.burst_cnt), 0);
    chk1("locked after release", u_a.locked, 0);

    // Lock with no CPU demand is never forced off.
    m0_req = 0;
    n_g1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_g1) n_g1++;
      next_cycle();
    end
    chkw("unforced lock grants", 19'(n_g1), 20);
    chk1("unforced lock locked", u_a.locked, 1);
    chkw("unforced lock burst_cnt", 19'(u_a.burst_cnt), 0);
    m0_req = 1;
    @(negedge clk);
    chk1("lock beats round-robin m1_gnt", a_g1, 1);
    chk1("lock beats round-robin m0_gnt", a_g0, 0);
    next_cycle();
    idle();
    next_cycle();

    // RD_LAT=2 return timing on u_b.
    m0_req = 1; m0_addr = 100;
    @(negedge clk);
    chk1("lat2 grant", b_g0, 1);
    next_cycle();
    idle();
    @(negedge clk);
    chk1("lat2 not yet valid", b_v0, 0);
    next_cycle();
    @(negedge clk);
    chk1("lat2 m0_rvalid", b_v0, 1);
    chkw("lat2 m0_rdata", b_d0, 138);
    next_cycle();

    // Two reads in flight on u_b, then reset mid-cycle.
    m0_req = 1; m0_addr = 100;
    next_cycle();
    idle();
    m1_req = 1; m1_addr = 200;
    next_cycle();
    rst = 1;
    m0_req = 1; m1_req = 1; m0_addr = 100; m1_addr = 200;
    @(negedge clk);
    chk_quiet("mid reset");
    next_cycle();
    @(negedge clk);
    chk_quiet("mid reset hold");
    next_cycle();
    rst = 0;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("post reset %0d b_m0_rvalid", k), b_v0, 0);
      chk1($sformatf("post reset %0d b_m1_rvalid", k), b_v1, 0);
      next_cycle();
    end
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    chk1("post reset contention b_m0_gnt", b_g0, 1);
    chk1("post reset contention b_m1_gnt", b_g1, 0);
    chk1("post reset contention a_m0_gnt", a_g0, 1);
    next_cycle();
    idle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the shared 19-bit data memory (mem_write, mem_read, addr, write_data, read_data).
- Requester 0 is the CPU pipeline load/store port; requester 1 is the FFT/crypto accelerator DMA port.
- Issues at most one memory transaction per cycle, using round-robin arbitration with a bounded accelerator burst lock.
- Returns read data to the owning requester with a tagged read-valid.

Parameters:
- AW, 19, address width.
- DW, 19, data width.
- RD_LAT, 1, cycles from an issued read to valid mem_rdata (1..4).
- MAX_BURST, 8, maximum consecutive locked grants to requester 1 while requester 0 is waiting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- m0_req  input  1  CPU request; held with fields stable until m0_gnt.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  AW  CPU address.
- m0_wdata  input  DW  CPU write data.
- m0_gnt  output  1  transaction accepted this cycle.
- m0_rvalid  output  1  m0_rdata valid.
- m0_rdata  output  DW  read return data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_ ports, for the accelerator.
- m1_lock  input  1  accelerator asks to keep ownership for a burst.
- mem_write  output  1  to memory.
- mem_read  output  1  to memory.
- mem_addr  output  AW  to memory.
- mem_wdata  output  DW  to memory.
- mem_rdata  input  DW  from memory; valid RD_LAT cycles after mem_read.

Behaviour:
- Registered state:
  - last_gnt (1 bit): reset value 1, so m0 wins the first contention.
  - burst_cnt (clog2(MAX_BURST+1) bits): reset value 0.
  - locked flag: reset value 0.
  - rd_pipe: RD_LAT entries of {valid, owner}, all valid bits reset to 0.
- Grant logic is combinational from reqs and state. Grant occurs in the same cycle as req.
  - While rst=1, all gnt, mem_write and mem_read are forced to 0.
- Winner selection:
  - Only one req asserted: that requester wins.
  - Both asserted and locked=1 with burst_cnt < MAX_BURST: m1 wins.
  - Both asserted otherwise: the requester that is not last_gnt wins.
  - Neither asserted: no grant, mem_write = mem_read = 0, mem_addr/mem_wdata hold the m0 fields (don't-care).
- Memory port: mem_addr, mem_wdata, mem_write (= winner_we) and mem_read (= ~winner_we) are muxed from the winner in the same cycle.
- On each grant edge:
  - last_gnt <= winner.
  - If the winner is a read, push {1, winner} into rd_pipe; otherwise push {0, x}.
- Lock and burst counter:
  - Locked is set when m1 is granted with m1_lock=1.
  - Locked clears when m1_lock=0, m1_req=0, or m0 is granted.
  - burst_cnt increments on each locked m1 grant while m0_req=1. It saturates at MAX_BURST.
  - burst_cnt clears whenever m0 is granted or locked clears.
  - At burst_cnt == MAX_BURST with m0_req=1, m0 wins the next cycle.
  - With m0_req=0 the lock holds indefinitely. This is a starvation bound only.
- Read return:
  - When the rd_pipe tail is valid, assert rvalid for exactly one cycle to the owner.
  - The owner's rdata = mem_rdata that cycle. The other requester's rvalid = 0.
  - rdata is 0 when not valid.
- Back-to-back reads by either requester every cycle are supported. Returns stay in issue order.
- Writes complete at the grant edge and produce no response.
- A read-after-write to the same address in consecutive cycles returns the new data; this is the memory's ordering, and the arbiter does not reorder.
- Reset asserted mid-operation:
  - rd_pipe is flushed, so in-flight reads produce no rvalid.
  - Lock and burst state clear immediately (async).
- A requester may drop req without a grant; no transaction occurs.

Decomposition:
- Shared package soc_mem_pkg:
  - AW/DW defaults.
  - Owner encoding (OWN_CPU=0, OWN_ACC=1).
  - MMIO base constant 19'h7F000, shared with the memory and decode logic.
- Sub-module mem_rd_tracker: RD_LAT-deep shift register of {valid, owner}. Outputs the tail valid/owner.
- Arbitration and lock logic stay in the top module.

Test Plan:
- Reset then m0 read, m0_addr=100: m0_gnt=1 same cycle, mem_read=1, mem_addr=100; m0_rvalid=1 one cycle later (RD_LAT=1) with m0_rdata=138 after a prior write of 138 to address 100.
- Both requesters assert unlocked reads for 4 cycles: grants alternate m0, m1, m0, m1; rvalid returns in the same order to the correct owner.
- m1_lock=1 with m0_req held, MAX_BURST=8: 8 consecutive m1 grants, then m0_gnt=1 on the 9th cycle, burst_cnt=0 after.
- m1 locked with m0_req=0 for 20 cycles: 20 m1 grants, no forced release.
- m0 writes 138 to 19'h7F000, next cycle m1 reads 19'h7F000: mem_write then mem_read; m1_rvalid=1 with m1_rdata=138.
- Assert rst while two reads are in flight (RD_LAT=2): no rvalid after reset; all outputs 0; the first post-reset contention is granted to m0.
